imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_decode_stage.sv | 132 +++++++++++++
 tb/tb_imm_decode_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Decodes the immediate field of an incoming instruction, classifies it and
//   computes the branch target. The result is held in a two-entry buffer: a
//   main register that drives out_*, and a skid register that absorbs one
//   extra entry while the consumer stalls.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   flush                 synchronous kill of both entries and the current input
//   in_valid/in_ready     fetch handshake; in_ready depends on state only
//   in_instr, in_pc       fetched instruction and its address
//   out_valid/out_ready   consumer handshake
//   out_instr, out_pc     passed through unchanged
//   out_imm, out_kind     extended immediate and class (0 NONE,1 B,2 CB,3 D,4 I)
//   out_target            pc + (imm << 2) for B/CB, otherwise pc
module imm_decode_stage #(
   parameter int PC_W = 64
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [PC_W-1:0] out_pc,
   output logic [PC_W-1:0] out_imm,
   output logic [2:0]      out_kind,
   output logic [PC_W-1:0] out_target
);

   localparam logic [2:0] KIND_NONE = 3'd0;
   localparam logic [2:0] KIND_B    = 3'd1;
   localparam logic [2:0] KIND_CB   = 3'd2;
   localparam logic [2:0] KIND_D    = 3'd3;
   localparam logic [2:0] KIND_I    = 3'd4;

   typedef struct packed {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] imm;
      logic [2:0]      kind;
      logic [PC_W-1:0] target;
   } entry_t;

   entry_t main_q, main_d, skid_q, skid_d, dec;
   logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic   accept, drain;

   // Decode and target are computed ahead of the registers so out_* are
   // pure flop outputs.
   always_comb begin
      dec       = '0;
      dec.instr = in_instr;
      dec.pc    = in_pc;
      dec.kind  = KIND_NONE;
      dec.imm   = '0;
      if (in_instr[31:26] == 6'b000101 || in_instr[31:26] == 6'b100101) begin
         dec.kind = KIND_B;
         dec.imm  = {{(PC_W-26){in_instr[25]}}, in_instr[25:0]};
      end else if (in_instr[31:24] == 8'b10110100 || in_instr[31:24] == 8'b10110101 ||
                   in_instr[31:24] == 8'b01010100) begin
         dec.kind = KIND_CB;
         dec.imm  = {{(PC_W-19){in_instr[23]}}, in_instr[23:5]};
      end else if (in_instr[31:21] == 11'b11111000010 || in_instr[31:21] == 11'b11111000000) begin
         dec.kind = KIND_D;
         dec.imm  = {{(PC_W-9){in_instr[20]}}, in_instr[20:12]};
      end else if (in_instr[31:22] == 10'b1001000100 || in_instr[31:22] == 10'b1101000100) begin
         dec.kind = KIND_I;
         dec.imm  = {{(PC_W-12){1'b0}}, in_instr[21:10]};
      end
      // Branch offsets are word counts; the add wraps mod 2^PC_W.
      if (dec.kind == KIND_B || dec.kind == KIND_CB)
         dec.target = in_pc + (dec.imm << 2);
      else
         dec.target = in_pc;
   end

   assign in_ready = !skid_valid_q;
   assign accept   = in_valid && in_ready;
   assign drain    = main_valid_q && out_ready;

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || drain) begin
         // Main is free this edge: the older skid entry goes first. When the
         // skid is valid in_ready is low, so no new input competes with it.
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = accept;
            if (accept) main_d = dec;
         end
      end else if (accept) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid  = main_valid_q;
   assign out_instr  = main_q.instr;
   assign out_pc     = main_q.pc;
   assign out_imm    = main_q.imm;
   assign out_kind   = main_q.kind;
   assign out_target = main_q.target;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, out_instr;
   logic [63:0] in_pc, out_pc, out_imm, out_target;
   logic [2:0]  out_kind;

   int total = 0;
   int bad   = 0;

   imm_decode_stage #(.PC_W(64)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_imm(out_imm), .out_kind(out_kind), .out_target(out_target)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
      logic [2:0]  kind;
      logic [63:0] imm;
      logic [63:0] target;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc);
      in_valid = v;
      in_instr = ins;
      in_pc    = pc;
   endtask

   task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
      out_ready = 1'b0;
      drive(1'b1, a, 64'h100);
      step();
      drive(1'b1, b, 64'h200);
      step();
      drive(1'b0, 32'h0, 64'h0);
   endtask

   initial begin
      vecs[0]  = '{32'h17FFFFFF, 64'h1000,   3'd1, 64'hFFFFFFFFFFFFFFFF, 64'h0FFC};
      vecs[1]  = '{32'hB4800000, 64'h200000, 3'd2, 64'hFFFFFFFFFFFC0000, 64'h100000};
      vecs[2]  = '{32'hF8500000, 64'h3000,   3'd3, 64'hFFFFFFFFFFFFFF00, 64'h3000};
      vecs[3]  = '{32'h913FFC00, 64'h4000,   3'd4, 64'h0000000000000FFF, 64'h4000};
      vecs[4]  = '{32'h14000010, 64'h100,    3'd1, 64'h10,               64'h140};
      vecs[5]  = '{32'h94000001, 64'h100,    3'd1, 64'h1,                64'h104};
      vecs[6]  = '{32'hB5000020, 64'h800,    3'd2, 64'h1,                64'h804};
      vecs[7]  = '{32'h54000040, 64'h800,    3'd2, 64'h2,                64'h808};
      vecs[8]  = '{32'hF8008000, 64'h900,    3'd3, 64'h8,                64'h900};
      vecs[9]  = '{32'hD1000400, 64'h900,    3'd4, 64'h1,                64'h900};
      vecs[10] = '{32'h00000000, 64'h1234,   3'd0, 64'h0,                64'h1234};
      vecs[11] = '{32'hFFFFFFFF, 64'h5678,   3'd0, 64'h0,                64'h5678};
      // Target wraps below zero
      vecs[12] = '{32'h17FFFFFF, 64'h0,      3'd1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC};
      // STUR sign bit set, ADDI zero-extends top bit
      vecs[13] = '{32'hF8100000, 64'hA0,     3'd3, 64'hFFFFFFFFFFFFFF00, 64'hA0};

      reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 32'h0, 64'h0);
      #12;
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_imm", out_imm, 64'd0);
      chk("rst_target", out_target, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

      // Back-to-back stream: each entry is visible exactly one edge after it is taken.
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, vecs[i].instr, vecs[i].pc);
         step();
         chk($sformatf("v%0d_valid", i), {63'b0, out_valid}, 64'd1);
         chk($sformatf("v%0d_instr", i), {32'b0, out_instr}, {32'b0, vecs[i].instr});
         chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
         chk($sformatf("v%0d_kind", i), {61'b0, out_kind}, {61'b0, vecs[i].kind});
         chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
         chk($sformatf("v%0d_target", i), out_target, vecs[i].target);
      end
      drive(1'b0, 32'h0, 64'h0);
      step();
      chk("drain_empty", {63'b0, out_valid}, 64'd0);

      // Backpressure: A, B taken, C refused until space frees; order kept.
      out_ready = 1'b0;
      drive(1'b1, 32'h14000001, 64'h0);
      step();
      chk("bp_a_out", {32'b0, out_instr}, 64'h14000001);
      chk("bp_rdy_after_a", {63'b0, in_ready}, 64'd1);
      drive(1'b1, 32'h14000002, 64'h0);
      step();
      chk("bp_full_rdy", {63'b0, in_ready}, 64'd0);
      chk("bp_hold_a", {32'b0, out_instr}, 64'h14000001);
      drive(1'b1, 32'h14000003, 64'h0);
      step();
      chk("bp_still_a", {32'b0, out_instr}, 64'h14000001);
      chk("bp_still_full", {63'b0, in_ready}, 64'd0);
      out_ready = 1'b1;
      step();
      chk("bp_b_out", {32'b0, out_instr}, 64'h14000002);
      chk("bp_b_valid", {63'b0, out_valid}, 64'd1);
      chk("bp_rdy_again", {63'b0, in_ready}, 64'd1);
      step();
      chk("bp_c_out", {32'b0, out_instr}, 64'h14000003);
      chk("bp_c_target", out_target, 64'hC);
      drive(1'b0, 32'h0, 64'h0);
      step();
      chk("bp_empty", {63'b0, out_valid}, 64'd0);

      // Flush with both entries full and an input presented.
      fill_two(32'h14000004, 32'h14000005);
      chk("fl_full", {63'b0, in_ready}, 64'd0);
      flush = 1'b1;
      drive(1'b1, 32'h14000006, 64'h0);
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 64'h0);
      chk("fl_out_valid", {63'b0, out_valid}, 64'd0);
      chk("fl_in_ready", {63'b0, in_ready}, 64'd1);
      out_ready = 1'b1;
      step();
      chk("fl_no_ghost", {63'b0, out_valid}, 64'd0);

      // Asynchronous reset mid-operation with both entries full.
      fill_two(32'h14000007, 32'h14000008);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_out_valid", {63'b0, out_valid}, 64'd0);
      chk("ar_instr", {32'b0, out_instr}, 64'd0);
      chk("ar_pc", out_pc, 64'd0);
      chk("ar_kind", {61'b0, out_kind}, 64'd0);
      chk("ar_target", out_target, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      out_ready = 1'b1;
      step();
      chk("ar_in_ready", {63'b0, in_ready}, 64'd1);
      chk("ar_empty", {63'b0, out_valid}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
